// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle for alu_exec_unit.
// The master offers operations and consumes results; the slave is the execute unit.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/logic/compare ops, iterative shifter
// moving SHIFT_STEP bit positions per cycle, valid/ready on both sides.
module alu_exec_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    alu_exec_unit_if.slave   bus_io
);
    localparam int unsigned    ShW  = $clog2(XLEN);
    localparam logic [ShW-1:0] Step = ShW'(SHIFT_STEP);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0010;
    localparam logic [3:0] OpOr    = 4'b0011;
    localparam logic [3:0] OpXor   = 4'b0100;
    localparam logic [3:0] OpSlt   = 4'b0101;
    localparam logic [3:0] OpSltu  = 4'b0110;
    localparam logic [3:0] OpSll   = 4'b0111;
    localparam logic [3:0] OpSrl   = 4'b1000;
    localparam logic [3:0] OpSra   = 4'b1001;
    localparam logic [3:0] OpClear = 4'b1010;
    localparam logic [3:0] OpPass  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [ShW-1:0]  cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic            is_shift;
    logic [ShW-1:0]  amt;
    logic [ShW-1:0]  k;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifted;

    assign bus_io.in_ready  = (state_q == StIdle) || (state_q == StDone && bus_io.out_ready);
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.result    = result_q;
    assign bus_io.zero      = zero_q;

    // Flush wins over a simultaneous offer, so the op is never taken.
    assign accept   = bus_io.in_valid && bus_io.in_ready && !flush_i;
    assign amt      = bus_io.src_b[ShW-1:0];
    assign is_shift = (bus_io.alu_op == OpSll) || (bus_io.alu_op == OpSrl) ||
                      (bus_io.alu_op == OpSra);

    // Shift ops reach this path only with a zero amount, so they pass A through.
    always_comb begin
        alu_res = '0;
        case (bus_io.alu_op)
            OpAdd:   alu_res = bus_io.src_a + bus_io.src_b;
            OpSub:   alu_res = bus_io.src_a - bus_io.src_b;
            OpAnd:   alu_res = bus_io.src_a & bus_io.src_b;
            OpOr:    alu_res = bus_io.src_a | bus_io.src_b;
            OpXor:   alu_res = bus_io.src_a ^ bus_io.src_b;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}},
                                $signed(bus_io.src_a) < $signed(bus_io.src_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, bus_io.src_a < bus_io.src_b};
            OpSll, OpSrl, OpSra, OpPass: alu_res = bus_io.src_a;
            OpClear: alu_res = bus_io.src_a & ~bus_io.src_b;
            default: alu_res = '0;
        endcase
    end

    // The accumulator keeps A's sign bit for sra, so an arithmetic step fills correctly.
    always_comb begin
        k = (cnt_q < Step) ? cnt_q : Step;
        case (op_q)
            OpSll:   shifted = acc_q << k;
            OpSrl:   shifted = acc_q >> k;
            default: shifted = $signed(acc_q) >>> k;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (state_q == StDone && bus_io.out_ready) begin
                        state_d = StIdle;
                    end
                    if (accept) begin
                        if (is_shift && amt != '0) begin
                            acc_d   = bus_io.src_a;
                            cnt_d   = amt;
                            op_d    = bus_io.alu_op;
                            state_d = StShift;
                        end else begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            state_d  = StDone;
                        end
                    end
                end
                StShift: begin
                    acc_d = shifted;
                    cnt_d = cnt_q - k;
                    if (cnt_q == k) begin
                        result_d = shifted;
                        zero_d   = (shifted == '0);
                        state_d  = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus hand-written handshake,
// flush and reset sequences; a second instance covers SHIFT_STEP=4.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_ni;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();
    alu_exec_unit_if #(.XLEN(32)) bus4 ();

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .bus_io  (bus.slave)
    );

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .bus_io  (bus4.slave)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one op on the main unit, scramble operands after accept, then time the result.
    task automatic run_op(input vec_t v);
        int guard;
        int lat;
        bus.alu_op   = v.op;
        bus.src_a    = v.a;
        bus.src_b    = v.b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({v.name, " accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a    = ~v.a;
        bus.src_b    = ~v.b;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " result"}, bus.result, v.res);
        check({v.name, " zero"}, 32'(bus.zero), 32'(v.z));
    endtask

    initial begin
        logic [31:0] held;
        int          cnt;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          cnt;
        int          lat;
        logic [31:0] a4[2];
        logic [31:0] b4[2];
        logic [31:0] r4[2];
        int          l4[2];

        vecs.push_back('{"add_ovf",  4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1});
        vecs.push_back('{"add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1});
        vecs.push_back('{"sub_eq",   4'h1, 32'h1234,      32'h1234,      32'h0,         1'b1, 1});
        vecs.push_back('{"sub_neg",  4'h1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1});
        vecs.push_back('{"and",      4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1});
        vecs.push_back('{"or",       4'h3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1});
        vecs.push_back('{"xor",      4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1});
        vecs.push_back('{"slt_neg",  4'h5, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1});
        vecs.push_back('{"slt_pos",  4'h5, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1});
        vecs.push_back('{"sltu",     4'h6, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1});
        vecs.push_back('{"sra31",    4'h9, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32});
        vecs.push_back('{"srl31",    4'h8, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32});
        vecs.push_back('{"sll0",     4'h7, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1});
        vecs.push_back('{"sll_hib",  4'h7, 32'h1,         32'hFFFF_FF24, 32'h10,        1'b0, 5});
        vecs.push_back('{"sra4",     4'h9, 32'h8000_0010, 32'd4,         32'hF800_0001, 1'b0, 5});
        vecs.push_back('{"pass",     4'hF, 32'hDEAD_BEEF, 32'h5,         32'hDEAD_BEEF, 1'b0, 1});
        vecs.push_back('{"clear",    4'hA, 32'hFF,        32'h0F,        32'hF0,        1'b0, 1});
        vecs.push_back('{"op1100",   4'hC, 32'h5,         32'h3,         32'h0,         1'b1, 1});

        rst_ni        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.alu_op    = '0;
        bus4.src_a     = '0;
        bus4.src_b     = '0;
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", bus.result, 32'h0);
        check("rst zero", 32'(bus.zero), 32'd1);
        rst_ni = 1'b1;
        #1;
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // in_ready must stay low for every SHIFT cycle of a 31-bit shift.
        @(posedge clk); #1;
        bus.alu_op = 4'h9; bus.src_a = 32'h8000_0000; bus.src_b = 32'd31; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.in_ready) cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("shift in_ready low cycles", 32'(cnt), 32'd31);
        @(posedge clk); #1;

        // Backpressure: hold a result, offer another op that must be refused.
        bus.out_ready = 1'b0;
        bus.alu_op = 4'h0; bus.src_a = 32'd5; bus.src_b = 32'd6; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.src_a = 32'd100; bus.src_b = 32'd100;
        check("bp first valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold result %0d", i), bus.result, 32'd11);
            check($sformatf("bp hold valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp in_ready %0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.src_a = 32'(i * 16 + 1);
            bus.src_b = 32'(i + 2);
            @(posedge clk); #1;
            check($sformatf("stream valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("stream result %0d", i), bus.result, 32'(i * 16 + 1 + i + 2));
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream drained", 32'(bus.out_valid), 32'd0);

        // Flush on cycle 10 of a shift, with a competing offer.
        held = bus.result;
        bus.alu_op = 4'h9; bus.src_a = 32'h8000_0000; bus.src_b = 32'd31; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.alu_op = 4'h0; bus.src_a = 32'd1; bus.src_b = 32'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush idle", 32'(bus.in_ready), 32'd1);
        check("flush result kept", bus.result, held);
        repeat (35) @(posedge clk);
        #1;
        check("flush no late result", 32'(bus.out_valid), 32'd0);

        // Reset mid-shift after a non-zero result.
        run_op('{"pre_rst", 4'hF, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1});
        bus.alu_op = 4'h9; bus.src_a = 32'h8000_0000; bus.src_b = 32'd31; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst shift out_valid", 32'(bus.out_valid), 32'd0);
        check("rst shift result", bus.result, 32'h0);
        check("rst shift zero", 32'(bus.zero), 32'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        #1;
        check("rst shift in_ready", 32'(bus.in_ready), 32'd1);
        repeat (35) @(posedge clk);
        #1;
        check("rst shift no result", 32'(bus.out_valid), 32'd0);

        // Reset while holding a result in DONE.
        bus.out_ready = 1'b0;
        bus.alu_op = 4'h0; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("done held", bus.result, 32'd7);
        rst_ni = 1'b0;
        #1;
        check("rst done out_valid", 32'(bus.out_valid), 32'd0);
        check("rst done result", bus.result, 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // SHIFT_STEP=4 instance: partial final step.
        a4[0] = 32'h1;         b4[0] = 32'h25; r4[0] = 32'h20;         l4[0] = 3;
        a4[1] = 32'h8000_0000; b4[1] = 32'd31; r4[1] = 32'hFFFF_FFFF; l4[1] = 9;
        bus4.alu_op = 4'h7;
        for (int i = 0; i < 2; i++) begin
            bus4.alu_op   = (i == 0) ? 4'h7 : 4'h9;
            bus4.src_a    = a4[i];
            bus4.src_b    = b4[i];
            bus4.in_valid = 1'b1;
            cnt = 0;
            while (!bus4.in_ready && cnt < 200) begin
                @(posedge clk); #1;
                cnt++;
            end
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            lat = 1;
            while (!bus4.out_valid && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("step4 latency %0d", i), 32'(lat), 32'(l4[i]));
            check($sformatf("step4 result %0d", i), bus4.result, r4[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
